// File: rtl/page_buffer_pkg.sv
// Shared definitions for the page_buffer ping-pong buffer.
//   BANKS         - number of storage banks used ping-pong
//   bank_state_e  - life cycle of one bank: FREE -> FILLING -> FULL -> DRAINING -> FREE
package page_buffer_pkg;

    localparam int BANKS = 2;

    typedef enum logic [1:0] {
        BANK_FREE     = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

endpackage

// File: rtl/page_buffer_bank_ram.sv
// bank_ram: one 2**AW x DW storage bank, inferred as block RAM.
// Ports:
//   clk     - clock
//   we_i    - write enable; stores wdata_i at waddr_i
//   waddr_i - write address
//   wdata_i - write data
//   re_i    - read enable; rdata_o loads mem[raddr_i] on the next edge
//   raddr_i - read address
//   rdata_o - registered read data, holds while re_i is low
// Contents and the read register are deliberately not reset.
module bank_ram #(
    parameter int DW = 1,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/page_buffer.sv
// page_buffer: two-bank ping-pong page buffer. The writer fills one bank
// while the reader drains the other; a page closes when the bank is full
// or on WRCOMMIT, after which the banks swap roles.
// Ports:
//   MCLK, nRESET         - clock, asynchronous active-low reset
//   nWRCLKEN, nWE, DIN   - write side enable (active low), strobe, data
//   WRCOMMIT             - close the current write page early
//   nRDCLKEN, nRD        - read side enable (active low), strobe
//   DOUT, DOUT_VALID     - read data (latency 1) and its one-cycle valid
//   RDLAST               - marks the final word of a page
//   WRREADY, RDREADY     - write bank free/filling, read bank full/draining
//   OVERRUN              - sticky: a write was dropped
module page_buffer
    import page_buffer_pkg::*;
#(
    parameter int DW = 1,
    parameter int AW = 10
) (
    input  logic          MCLK,
    input  logic          nRESET,
    input  logic          nWRCLKEN,
    input  logic          nWE,
    input  logic [DW-1:0] DIN,
    input  logic          WRCOMMIT,
    input  logic          nRDCLKEN,
    input  logic          nRD,
    output logic [DW-1:0] DOUT,
    output logic          DOUT_VALID,
    output logic          RDLAST,
    output logic          WRREADY,
    output logic          RDREADY,
    output logic          OVERRUN
);

    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    bank_state_e   state_q [BANKS];
    bank_state_e   state_d [BANKS];
    logic [AW:0]   len_q   [BANKS];
    logic [AW:0]   len_d   [BANKS];
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          overrun_q;
    logic          dout_valid_q, rdlast_q;
    logic          dout_live_q;   // some read has completed since reset
    logic          dout_sel_q;    // bank whose read register drives DOUT
    logic [DW-1:0] ram_rdata [BANKS];

    logic wr_ready, rd_ready;
    logic wr_acc, wr_drop, wr_close;
    logic rd_acc, rd_last;

    assign wr_ready = (state_q[wr_bank_q] == BANK_FREE) || (state_q[wr_bank_q] == BANK_FILLING);
    assign rd_ready = (state_q[rd_bank_q] == BANK_FULL) || (state_q[rd_bank_q] == BANK_DRAINING);

    assign wr_acc  = !nWRCLKEN && !nWE && wr_ready;
    assign wr_drop = !nWRCLKEN && !nWE && !wr_ready;
    // A commit closes the page if it already holds data or gains a word this cycle.
    assign wr_close = (wr_acc && (waddr_q == LAST_ADDR))
                   || (!nWRCLKEN && WRCOMMIT && wr_ready && ((len_q[wr_bank_q] != '0) || wr_acc));

    assign rd_acc  = !nRDCLKEN && !nRD && rd_ready;
    assign rd_last = ({1'b0, raddr_q} == (len_q[rd_bank_q] - 1'b1));

    // Write and read never touch the same bank: the write bank is FREE/FILLING
    // whenever a write is accepted, the read bank FULL/DRAINING whenever a read is.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        waddr_d   = waddr_q;
        raddr_d   = raddr_q;

        if (wr_acc) begin
            waddr_d            = waddr_q + 1'b1;
            len_d[wr_bank_q]   = len_q[wr_bank_q] + 1'b1;
            state_d[wr_bank_q] = BANK_FILLING;
        end
        if (wr_close) begin
            state_d[wr_bank_q] = BANK_FULL;
            wr_bank_d          = ~wr_bank_q;
            waddr_d            = '0;
        end

        if (rd_acc) begin
            raddr_d            = raddr_q + 1'b1;
            state_d[rd_bank_q] = BANK_DRAINING;
            if (rd_last) begin
                state_d[rd_bank_q] = BANK_FREE;
                len_d[rd_bank_q]   = '0;
                rd_bank_d          = ~rd_bank_q;
                raddr_d            = '0;
            end
        end
    end

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < BANKS; i++) begin
                state_q[i] <= BANK_FREE;
                len_q[i]   <= '0;
            end
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            waddr_q      <= '0;
            raddr_q      <= '0;
            overrun_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            rdlast_q     <= 1'b0;
            dout_live_q  <= 1'b0;
            dout_sel_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            waddr_q      <= waddr_d;
            raddr_q      <= raddr_d;
            overrun_q    <= overrun_q | wr_drop;
            dout_valid_q <= rd_acc;
            rdlast_q     <= rd_acc && rd_last;
            if (rd_acc) begin
                dout_live_q <= 1'b1;
                dout_sel_q  <= rd_bank_q;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BANKS; gi++) begin : g_bank
            bank_ram #(
                .DW (DW),
                .AW (AW)
            ) u_bank_ram (
                .clk     (MCLK),
                .we_i    (wr_acc && (wr_bank_q == 1'(gi))),
                .waddr_i (waddr_q),
                .wdata_i (DIN),
                .re_i    (rd_acc && (rd_bank_q == 1'(gi))),
                .raddr_i (raddr_q),
                .rdata_o (ram_rdata[gi])
            );
        end
    endgenerate

    // Each bank's read register only moves on its own read, so selecting the
    // last-read bank makes DOUT hold between reads; it reads 0 until the first read.
    assign DOUT       = dout_live_q ? ram_rdata[dout_sel_q] : '0;
    assign DOUT_VALID = dout_valid_q;
    assign RDLAST     = rdlast_q;
    assign WRREADY    = wr_ready;
    assign RDREADY    = rd_ready;
    assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_page_buffer.sv
// Self-checking bench for page_buffer (DW=8, AW=4) against a queue-based
// model: completed pages are a flat word queue plus a queue of page lengths.
module tb_page_buffer;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 2**AW;

    logic          MCLK;
    logic          nRESET;
    logic          nWRCLKEN, nWE, WRCOMMIT;
    logic [DW-1:0] DIN;
    logic          nRDCLKEN, nRD;
    logic [DW-1:0] DOUT;
    logic          DOUT_VALID, RDLAST, WRREADY, RDREADY, OVERRUN;

    page_buffer #(.DW(DW), .AW(AW)) dut (
        .MCLK       (MCLK),
        .nRESET     (nRESET),
        .nWRCLKEN   (nWRCLKEN),
        .nWE        (nWE),
        .DIN        (DIN),
        .WRCOMMIT   (WRCOMMIT),
        .nRDCLKEN   (nRDCLKEN),
        .nRD        (nRD),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .RDLAST     (RDLAST),
        .WRREADY    (WRREADY),
        .RDREADY    (RDREADY),
        .OVERRUN    (OVERRUN)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [DW-1:0] m_data[$];   // words of all closed, unread pages, oldest first
    int            m_lens[$];   // lengths of closed pages, oldest first
    logic [DW-1:0] m_fill[$];   // page currently being written
    int            m_rdpos;     // words already read from the oldest page
    logic [DW-1:0] m_dout;
    logic          m_valid, m_last, m_ovr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_data.delete();
        m_lens.delete();
        m_fill.delete();
        m_rdpos = 0;
        m_dout  = '0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic check_outputs(input string phase);
        check_eq({phase, ".DOUT"},       32'(DOUT),       32'(m_dout));
        check_eq({phase, ".DOUT_VALID"}, 32'(DOUT_VALID), 32'(m_valid));
        check_eq({phase, ".RDLAST"},     32'(RDLAST),     32'(m_last));
        check_eq({phase, ".OVERRUN"},    32'(OVERRUN),    32'(m_ovr));
    endtask

    task automatic check_ready(input string phase);
        check_eq({phase, ".WRREADY"}, 32'(WRREADY), 32'(m_lens.size() < 2));
        check_eq({phase, ".RDREADY"}, 32'(RDREADY), 32'(m_lens.size() > 0));
    endtask

    // One clock cycle; called and returning just after a falling edge.
    task automatic tick(input logic wce_n, input logic we_n, input logic [DW-1:0] d,
                        input logic commit, input logic rce_n, input logic rd_n);
        bit wr_rdy, rd_rdy, acc;
        nWRCLKEN = wce_n;
        nWE      = we_n;
        DIN      = d;
        WRCOMMIT = commit;
        nRDCLKEN = rce_n;
        nRD      = rd_n;
        #1;
        check_ready("pre");
        wr_rdy = (m_lens.size() < 2);
        rd_rdy = (m_lens.size() > 0);
        @(posedge MCLK);
        m_valid = 1'b0;
        m_last  = 1'b0;
        if (!rce_n && !rd_n && rd_rdy) begin
            m_dout  = m_data.pop_front();
            m_valid = 1'b1;
            m_rdpos++;
            if (m_rdpos == m_lens[0]) begin
                void'(m_lens.pop_front());
                m_rdpos = 0;
                m_last  = 1'b1;
            end
        end
        if (!wce_n) begin
            acc = !we_n && wr_rdy;
            if (!we_n && !wr_rdy) m_ovr = 1'b1;
            if (acc) m_fill.push_back(d);
            if (wr_rdy && ((acc && m_fill.size() == DEPTH) || (commit && m_fill.size() > 0))) begin
                foreach (m_fill[i]) m_data.push_back(m_fill[i]);
                m_lens.push_back(m_fill.size());
                m_fill.delete();
            end
        end
        #1;
        check_outputs("post");
        @(negedge MCLK);
    endtask

    task automatic idle_inputs();
        nWRCLKEN = 1'b1;
        nWE      = 1'b1;
        DIN      = '0;
        WRCOMMIT = 1'b0;
        nRDCLKEN = 1'b1;
        nRD      = 1'b1;
    endtask

    // Asynchronous reset pulse starting between clock edges.
    task automatic do_reset();
        idle_inputs();
        #2;
        nRESET = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        check_ready("rst");
        @(negedge MCLK);
        nRESET = 1'b1;
    endtask

    task automatic wr(input logic [DW-1:0] d, input logic commit);
        tick(1'b0, 1'b0, d, commit, 1'b1, 1'b1);
    endtask

    task automatic rd();
        tick(1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        idle_inputs();
        nRESET = 1'b0;
        #3;
        check_outputs("init");
        check_ready("init");
        @(negedge MCLK);
        nRESET = 1'b1;

        // Full 16-word page, then read it back plus one extra read.
        for (int i = 0; i < DEPTH; i++) wr(8'(i), 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) rd();
        $display("scenario full_page checks=%0d failures=%0d", n_checks, n_fail);

        // Short page closed by WRCOMMIT on the third word.
        wr(8'h31, 1'b0);
        wr(8'h32, 1'b0);
        wr(8'h33, 1'b1);
        tick(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);   // commit on empty page: ignored
        for (int i = 0; i < 4; i++) rd();
        $display("scenario commit checks=%0d failures=%0d", n_checks, n_fail);

        // Both banks full, then a dropped write.
        for (int i = 0; i < 2 * DEPTH; i++) wr(8'(8'h40 + i), 1'b0);
        wr(8'hAA, 1'b0);
        for (int i = 0; i < 2 * DEPTH + 1; i++) rd();
        $display("scenario overrun checks=%0d failures=%0d", n_checks, n_fail);

        // Concurrent fill and drain, then a write right after RDLAST.
        for (int i = 0; i < DEPTH; i++) wr(8'(8'h80 + i), 1'b0);
        for (int i = 0; i < DEPTH; i++) tick(1'b0, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        wr(8'hEE, 1'b1);
        for (int i = 0; i < DEPTH + 2; i++) rd();
        $display("scenario concurrent checks=%0d failures=%0d", n_checks, n_fail);

        // Reset in the middle of a fill, then a fresh page.
        for (int i = 0; i < 5; i++) wr(8'(8'h10 + i), 1'b0);
        do_reset();
        for (int i = 0; i < DEPTH; i++) wr(8'(8'h60 + i), 1'b0);
        for (int i = 0; i < DEPTH; i++) rd();
        $display("scenario reset_mid_fill checks=%0d failures=%0d", n_checks, n_fail);

        // Clock enables deasserted with strobes active.
        wr(8'h71, 1'b0);
        wr(8'h72, 1'b1);
        rd();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1);
        rd();
        rd();
        $display("scenario clken checks=%0d failures=%0d", n_checks, n_fail);

        // Randomised traffic with varying write/read bias.
        for (int blk = 0; blk < 8; blk++) begin
            int wbias = $urandom_range(1, 4);
            int rbias = $urandom_range(1, 4);
            for (int c = 0; c < 150; c++) begin
                tick(($urandom % 8) == 0,
                     ($urandom % wbias) != 0,
                     8'($urandom),
                     ($urandom % 16) == 0,
                     ($urandom % 8) == 0,
                     ($urandom % rbias) != 0);
            end
            if (blk == 4) do_reset();
        end
        $display("scenario random checks=%0d failures=%0d", n_checks, n_fail);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
